// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM master arbiter and the masters it serves.
package sdram_arb_pkg;

  // Default bus widths shared with the wordcopy engine and the DNN accelerator masters.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // Width of a requester ID; never below one bit so a single-port build still elaborates.
  function automatic int req_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of requester IDs for reads accepted by the SDRAM but not yet answered.
module resp_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_id,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // Head is read before any same-cycle push lands, so a pop always sees the oldest ID.
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible between their push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master between NUM_REQ requesters.
// Handshake: a command (read or write strobe) transfers on a clock edge where the strobe
// is high and the matching waitrequest is low; the requester must hold address, data and
// strobe stable while waitrequest is high. Read data returns on readdatavalid, in order.
module sdram_master_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  input  logic                          master_waitrequest,
  output logic [ADDR_W-1:0]             master_address,
  output logic                          master_read,
  output logic                          master_write,
  output logic [DATA_W-1:0]             master_writedata,
  input  logic [DATA_W-1:0]             master_readdata,
  input  logic                          master_readdatavalid,
  output logic                          resp_error,
  output arb_state_t                    dbg_state,
  output logic [$clog2(MAX_OUTSTANDING):0] dbg_fifo_count
);

  localparam int REQ_ID_W = req_id_w(NUM_REQ);

  arb_state_t          state;
  logic [REQ_ID_W-1:0] grant;
  logic [REQ_ID_W-1:0] rr_ptr;
  logic [REQ_ID_W-1:0] next_grant;
  logic [REQ_ID_W-1:0] idx;
  logic                found;
  logic                any_req;
  logic                g_read;
  logic                g_write;
  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [REQ_ID_W-1:0] head_id;

  assign any_req   = |(req_read | req_write);
  assign g_read    = req_read[grant];
  assign g_write   = req_write[grant];
  assign accept    = (master_read | master_write) & ~master_waitrequest;
  assign push      = master_read & ~master_waitrequest;
  assign pop       = master_readdatavalid & ~fifo_empty;
  assign req_readdata = master_readdata;
  assign dbg_state = state;

  // Pick the first requesting port at or after rr_ptr, wrapping around.
  always_comb begin
    next_grant = rr_ptr;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = REQ_ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && (req_read[idx] || req_write[idx])) begin
        next_grant = idx;
        found      = 1'b1;
      end
    end
  end

  // Forward the granted port; reads wait while every response slot is taken, and a read wins
  // over a simultaneous write from the same port.
  always_comb begin
    req_waitrequest  = '1;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    if (state == GRANTED) begin
      master_address         = req_address[int'(grant)*ADDR_W +: ADDR_W];
      master_writedata       = req_writedata[int'(grant)*DATA_W +: DATA_W];
      master_read            = g_read & ~fifo_full;
      master_write           = g_write & ~g_read;
      req_waitrequest[grant] = master_waitrequest | (g_read & fifo_full);
    end
  end

  // Route each response to the port at the head of the ID FIFO.
  always_comb begin
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[head_id] = 1'b1;
  end

  // Arbitration FSM: one grant cycle, then hold the grant until the command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (accept) begin
            rr_ptr <= (grant == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end else if (!g_read && !g_write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response with nothing outstanding is latched until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_error <= 1'b0;
    else if (master_readdatavalid && fifo_empty) resp_error <= 1'b1;
  end

  resp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REQ_ID_W)
  ) u_resp_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_id (grant),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id),
    .count   (dbg_fifo_count)
  );

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Self-checking bench for sdram_master_arbiter: requester drivers, an SDRAM slave model and
// a transaction-level scoreboard of issued reads and their owners.
module tb_sdram_master_arbiter;
  import sdram_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;
  logic                      master_waitrequest;
  logic [ADDR_W-1:0]         master_address;
  logic                      master_read;
  logic                      master_write;
  logic [DATA_W-1:0]         master_writedata;
  logic [DATA_W-1:0]         master_readdata;
  logic                      master_readdatavalid;
  logic                      resp_error;
  arb_state_t                dbg_state;
  logic [$clog2(MAX_OUT):0]  dbg_fifo_count;

  sdram_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .resp_error(resp_error), .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
  );

  // ---------------- bench state ----------------
  cmd_t              cq [NUM_REQ][$];   // pending commands per requester, head is presented
  logic [DATA_W-1:0] sd_data_q[$];      // SDRAM model: data of accepted reads
  int                sd_due_q[$];
  logic [0:0]        exp_q[$];          // scoreboard: owner of each outstanding read
  logic [DATA_W-1:0] exp_data_q[$];
  logic [1:0]        rdv_log[$];
  int                rdv_cyc_log[$];
  logic [0:0]        acc_log[$];

  int   cyc;
  bit   hold_mwr, fire_now, spur_now, resp_auto, rand_stall, force_data_v;
  int   stall_left, resp_lat;
  logic [DATA_W-1:0] force_data;
  bit   acc [NUM_REQ];
  bit   exp_err, last_valid, last_other_vis;
  int   last_id, last_acc_cyc, last_rdv_cyc;

  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- monitor / scoreboard (negedge) ----------------
  task automatic monitor();
    int zeros;
    int gi;
    int lat;
    logic [0:0] id;
    logic [1:0] oh;
    logic [DATA_W-1:0] d;
    cmd_t h;
    if (!rst_n) begin
      check_eq("rst_waitreq", req_waitrequest, 2'b11);
      check_eq("rst_mread", master_read, 0);
      check_eq("rst_mwrite", master_write, 0);
      check_eq("rst_maddr", master_address, 0);
      check_eq("rst_mwdata", master_writedata, 0);
      check_eq("rst_rdv", req_readdatavalid, 0);
      check_eq("rst_resp_error", resp_error, 0);
      check_eq("rst_state", dbg_state, IDLE);
      exp_q.delete();
      exp_data_q.delete();
      exp_err    = 0;
      last_valid = 0;
      for (int i = 0; i < NUM_REQ; i++) acc[i] = 0;
      return;
    end
    check_eq("resp_error", resp_error, exp_err);
    if (exp_q.size() == MAX_OUT) check_eq("full_blocks_read", master_read, 0);
    if (master_readdatavalid) begin
      if (exp_q.size() > 0) begin
        id = exp_q.pop_front();
        d  = exp_data_q.pop_front();
        oh = 2'b01 << id;
        check_eq("rdv_route", req_readdatavalid, oh);
        check_eq("rdv_data", req_readdata, d);
        rdv_log.push_back(req_readdatavalid);
        rdv_cyc_log.push_back(cyc);
        last_rdv_cyc = cyc;
      end else begin
        check_eq("spurious_no_strobe", req_readdatavalid, 0);
        exp_err = 1;
      end
    end else begin
      check_eq("no_strobe", req_readdatavalid, 0);
    end
    if ((master_read || master_write) && master_waitrequest && stall_left > 0) stall_left--;
    if ((master_read || master_write) && !master_waitrequest) begin
      zeros = 0;
      gi    = 0;
      for (int i = 0; i < NUM_REQ; i++) if (!req_waitrequest[i]) begin zeros++; gi = i; end
      check_eq("one_granted", zeros, 1);
      check_eq("acc_has_cmd", cq[gi].size() > 0, 1);
      if (zeros == 1 && cq[gi].size() > 0) begin
        h = cq[gi][0];
        check_eq("acc_type_read", master_read, h.rd);
        check_eq("acc_type_write", master_write, !h.rd);
        check_eq("acc_addr", master_address, h.addr);
        if (!h.rd) check_eq("acc_wdata", master_writedata, h.data);
        if (last_valid) begin
          check_eq("min_two_cycles", (cyc - last_acc_cyc) >= 2, 1);
          check_eq("rr_fair", (last_id == gi) && last_other_vis, 0);
        end
        last_other_vis = req_read[1-gi] | req_write[1-gi];
        last_id        = gi;
        last_valid     = 1;
        last_acc_cyc   = cyc;
        acc[gi]        = 1;
        acc_log.push_back(gi[0]);
        if (h.rd) begin
          d   = force_data_v ? force_data : $urandom();
          lat = (resp_lat > 0) ? resp_lat : $urandom_range(1, 6);
          exp_q.push_back(gi[0]);
          exp_data_q.push_back(d);
          sd_data_q.push_back(d);
          sd_due_q.push_back(cyc + lat);
        end
      end
    end
  endtask

  // ---------------- drivers (posedge + 1) ----------------
  task automatic drive();
    if (!rst_n) for (int i = 0; i < NUM_REQ; i++) cq[i].delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && cq[i].size() > 0) void'(cq[i].pop_front());
      acc[i] = 0;
      req_read[i]  = (cq[i].size() > 0) && cq[i][0].rd;
      req_write[i] = (cq[i].size() > 0) && !cq[i][0].rd;
      req_address[i*ADDR_W +: ADDR_W]   = (cq[i].size() > 0) ? cq[i][0].addr : '0;
      req_writedata[i*DATA_W +: DATA_W] = (cq[i].size() > 0) ? cq[i][0].data : '0;
    end
    master_waitrequest = hold_mwr || (stall_left > 0) || (rand_stall && $urandom_range(0, 3) == 0);
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    if (spur_now) begin
      master_readdatavalid = 1'b1;
      master_readdata      = $urandom();
      spur_now             = 0;
    end else if (sd_data_q.size() > 0 && (fire_now || (resp_auto && sd_due_q[0] <= cyc))) begin
      master_readdatavalid = 1'b1;
      master_readdata      = sd_data_q.pop_front();
      void'(sd_due_q.pop_front());
      fire_now             = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive();
    end
  end

  // ---------------- test helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic issue(input int port, input logic rd, input logic [ADDR_W-1:0] addr);
    int t;
    cq[port].push_back('{rd, addr, $urandom()});
    t = 0;
    while (cq[port].size() > 0 && t < 100) begin step(1); t++; end
    check_eq("issue_timeout", t < 100, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((cq[0].size() > 0 || cq[1].size() > 0 || exp_q.size() > 0) && t < 3000) begin
      step(1);
      t++;
    end
    check_eq("drain_timeout", t < 3000, 1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int t;
    int stalled;
    int n0;
    n_checks = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b0;
    req_read = '0; req_write = '0; req_address = '0; req_writedata = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    hold_mwr = 0; fire_now = 0; spur_now = 0; resp_auto = 1; rand_stall = 0;
    force_data_v = 0; force_data = '0; stall_left = 0; resp_lat = 3;
    exp_err = 0; last_valid = 0; last_other_vis = 0; last_id = 0;
    last_acc_cyc = 0; last_rdv_cyc = -1;
    for (int i = 0; i < NUM_REQ; i++) acc[i] = 0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Single read from port 0: one grant cycle, then the read; response routed to port 0.
    force_data_v = 1; force_data = 32'hDEADBEEF; resp_lat = 3;
    cq[0].push_back('{1'b1, 32'h100, 32'h0});
    step(1);
    check_eq("t1_grant_cycle_idle", master_read, 0);
    step(1);
    check_eq("t1_read_issued", master_read, 1);
    check_eq("t1_read_addr", master_address, 32'h100);
    check_eq("t1_waitreq", req_waitrequest, 2'b10);
    t = 0;
    while (req_readdatavalid == 0 && t < 20) begin step(1); t++; end
    check_eq("t1_rdv", req_readdatavalid, 2'b01);
    check_eq("t1_rdata", req_readdata, 32'hDEADBEEF);
    force_data_v = 0;
    drain();

    // Both ports writing continuously alternate without starvation.
    acc_log.delete();
    for (int k = 0; k < 4; k++) begin
      cq[0].push_back('{1'b0, 32'h1000 + k, $urandom()});
      cq[1].push_back('{1'b0, 32'h2000 + k, $urandom()});
    end
    drain();
    check_eq("t2_count", acc_log.size(), 8);
    n0 = 0;
    for (int j = 0; j < acc_log.size(); j++) begin
      if (acc_log[j] == 0) n0++;
      if (j > 0) check_eq("t2_alternate", acc_log[j] != acc_log[j-1], 1);
    end
    check_eq("t2_balance", n0, 4);

    // Port 1 write stalled by the SDRAM for five cycles; port 0 must wait.
    stall_left = 5;
    cq[1].push_back('{1'b0, 32'h200, 32'hA5A5_0001});
    t = 0;
    while (!master_write && t < 10) begin step(1); t++; end
    stalled = 0;
    while (master_write && master_waitrequest && t < 30) begin
      stalled++;
      check_eq("t3_addr_stable", master_address, 32'h200);
      check_eq("t3_waitreq_all", req_waitrequest, 2'b11);
      if (stalled == 1) cq[0].push_back('{1'b0, 32'h300, 32'hA5A5_0002});
      step(1);
      t++;
    end
    check_eq("t3_stall_cycles", stalled, 5);
    drain();
    check_eq("t3_order_last", acc_log[acc_log.size()-1], 0);
    check_eq("t3_order_prev", acc_log[acc_log.size()-2], 1);

    // Four outstanding reads fill the ID FIFO; the fifth waits for the first response.
    resp_lat = 40;
    rdv_log.delete(); rdv_cyc_log.delete();
    issue(0, 1'b1, 32'h10);
    issue(1, 1'b1, 32'h14);
    issue(1, 1'b1, 32'h18);
    issue(0, 1'b1, 32'h1C);
    cq[1].push_back('{1'b1, 32'h20, 32'h0});
    step(5);
    check_eq("t4_fifth_stalled", cq[1].size(), 1);
    check_eq("t4_occupancy_full", dbg_fifo_count, 4);
    check_eq("t4_no_read_when_full", master_read, 0);
    t = 0;
    while (cq[1].size() > 0 && t < 100) begin step(1); t++; end
    check_eq("t4_fifth_timeout", t < 100, 1);
    check_eq("t4_fifth_after_rdv", rdv_cyc_log.size() > 0 && last_acc_cyc > rdv_cyc_log[0], 1);
    drain();
    check_eq("t4_rdv_count", rdv_log.size(), 5);
    if (rdv_log.size() == 5) begin
      check_eq("t4_route0", rdv_log[0], 2'b01);
      check_eq("t4_route1", rdv_log[1], 2'b10);
      check_eq("t4_route2", rdv_log[2], 2'b10);
      check_eq("t4_route3", rdv_log[3], 2'b01);
      check_eq("t4_route4", rdv_log[4], 2'b10);
    end

    // Push and pop in the same cycle at occupancy 2.
    resp_auto = 0;
    rdv_log.delete();
    issue(0, 1'b1, 32'h40);
    issue(1, 1'b1, 32'h44);
    check_eq("t5_occ_before", dbg_fifo_count, 2);
    hold_mwr = 1;
    cq[0].push_back('{1'b1, 32'h48, 32'h0});
    t = 0;
    while (!master_read && t < 10) begin step(1); t++; end
    check_eq("t5_read_visible", master_read, 1);
    hold_mwr = 0;
    fire_now = 1;
    step(2);
    check_eq("t5_occ_after", dbg_fifo_count, 2);
    check_eq("t5_same_cycle", last_acc_cyc, last_rdv_cyc);
    fire_now = 1; step(2);
    fire_now = 1; step(2);
    check_eq("t5_occ_empty", dbg_fifo_count, 0);
    check_eq("t5_rdv_count", rdv_log.size(), 3);
    if (rdv_log.size() == 3) begin
      check_eq("t5_route0", rdv_log[0], 2'b01);
      check_eq("t5_route1", rdv_log[1], 2'b10);
      check_eq("t5_route2", rdv_log[2], 2'b01);
    end

    // Unsolicited response sets a sticky error; reset clears it and drops outstanding IDs.
    spur_now = 1;
    step(2);
    check_eq("t6_err_set", resp_error, 1);
    step(4);
    check_eq("t6_err_sticky", resp_error, 1);
    issue(0, 1'b1, 32'h50);
    issue(1, 1'b1, 32'h54);
    check_eq("t6_occ_two", dbg_fifo_count, 2);
    rst_n = 1'b0;
    step(1);
    check_eq("t6_rst_err", resp_error, 0);
    check_eq("t6_rst_occ", dbg_fifo_count, 0);
    check_eq("t6_rst_waitreq", req_waitrequest, 2'b11);
    rst_n = 1'b1;
    step(1);
    fire_now = 1;
    step(2);
    check_eq("t6_late_err", resp_error, 1);
    fire_now = 1;
    step(2);
    sd_data_q.delete(); sd_due_q.delete();
    do_reset();
    check_eq("t6_err_cleared", resp_error, 0);

    // Randomized mixed traffic with random SDRAM stalls and latencies.
    resp_auto = 1; resp_lat = 0; rand_stall = 1;
    for (int k = 0; k < 80; k++) begin
      cq[$urandom_range(0, 1)].push_back('{1'($urandom_range(0, 1)), $urandom(), $urandom()});
      step($urandom_range(0, 3));
    end
    drain();
    rand_stall = 0;
    step(10);
    check_eq("final_no_outstanding", dbg_fifo_count, 0);
    check_eq("final_no_error", resp_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
